// File: rtl/sys_ctrl_cmd_decoder.sv
// rtl/sys_ctrl_cmd_decoder.sv - decodes RX command frames into register-file/ALU transactions and returns result bytes
module sys_ctrl_cmd_decoder #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int TIMEOUT       = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
    input  logic                     RF_RD_VLD,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     TX_FIFO_FULL,
    output logic                     RF_WR_EN,
    output logic                     RF_RD_EN,
    output logic [ADDR_WIDTH-1:0]    RF_ADDR,
    output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
    output logic                     ALU_EN,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     CMD_ERR
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'('hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'('hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'('hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'('hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
        ALU_FUN_S, ALU_WAIT, TX_RD, TX_LO, TX_HI
    } state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0]    rd_q, rd_nxt;
    logic [ALU_OUT_WIDTH-1:0] res_q, res_nxt;
    logic                     wr_en_nxt, rd_en_nxt, alu_en_nxt, gate_nxt, tx_vld_nxt, err_nxt;
    logic [ADDR_WIDTH-1:0]    rf_addr_nxt;
    logic [DATA_WIDTH-1:0]    wr_data_nxt, tx_data_nxt;
    logic [FUN_WIDTH-1:0]     fun_nxt;
    logic                     expired;

    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            rd_q        <= '0;
            res_q       <= '0;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            RF_ADDR     <= '0;
            RF_WR_DATA  <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            CMD_ERR     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            addr_q      <= addr_nxt;
            rd_q        <= rd_nxt;
            res_q       <= res_nxt;
            RF_WR_EN    <= wr_en_nxt;
            RF_RD_EN    <= rd_en_nxt;
            RF_ADDR     <= rf_addr_nxt;
            RF_WR_DATA  <= wr_data_nxt;
            ALU_EN      <= alu_en_nxt;
            ALU_FUN     <= fun_nxt;
            CLK_GATE_EN <= gate_nxt;
            TX_P_DATA   <= tx_data_nxt;
            TX_D_VLD    <= tx_vld_nxt;
            CMD_ERR     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt == '1) ? cnt : cnt + 1'b1;
        addr_nxt    = addr_q;
        rd_nxt      = rd_q;
        res_nxt     = res_q;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        tx_vld_nxt  = 1'b0;
        err_nxt     = 1'b0;
        rf_addr_nxt = RF_ADDR;
        wr_data_nxt = RF_WR_DATA;
        fun_nxt     = ALU_FUN;
        alu_en_nxt  = ALU_EN;
        gate_nxt    = CLK_GATE_EN;
        tx_data_nxt = TX_P_DATA;
        case (state)
            IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    CMD_WR:     state_nxt = WR_ADDR;
                    CMD_RD:     state_nxt = RD_ADDR;
                    CMD_ALU_OP: state_nxt = OP_A;
                    CMD_ALU_NO: state_nxt = ALU_FUN_S;
                    default:    err_nxt   = 1'b1;
                endcase
            end
            WR_ADDR: if (RX_D_VLD) begin
                addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_nxt = WR_DATA;
            end
            WR_DATA: if (RX_D_VLD) begin
                rf_addr_nxt = addr_q;
                wr_data_nxt = RX_P_DATA;
                wr_en_nxt   = 1'b1;
                state_nxt   = IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
                rf_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                rd_en_nxt   = 1'b1;
                cnt_nxt     = '0;
                state_nxt   = RD_WAIT;
            end
            RD_WAIT: begin
                err_nxt = RX_D_VLD;
                if (RF_RD_VLD) begin
                    rd_nxt    = RF_RD_DATA;
                    state_nxt = TX_RD;
                end else if (expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            OP_A: if (RX_D_VLD) begin
                rf_addr_nxt = '0;
                wr_data_nxt = RX_P_DATA;
                wr_en_nxt   = 1'b1;
                state_nxt   = OP_B;
            end
            OP_B: if (RX_D_VLD) begin
                rf_addr_nxt = ADDR_WIDTH'(1);
                wr_data_nxt = RX_P_DATA;
                wr_en_nxt   = 1'b1;
                state_nxt   = ALU_FUN_S;
            end
            ALU_FUN_S: if (RX_D_VLD) begin
                fun_nxt    = RX_P_DATA[FUN_WIDTH-1:0];
                alu_en_nxt = 1'b1;
                gate_nxt   = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = ALU_WAIT;
            end
            ALU_WAIT: begin
                // The enables stay high through the cycle the result is sampled
                err_nxt = RX_D_VLD;
                if (ALU_OUT_VLD) begin
                    res_nxt    = ALU_OUT;
                    alu_en_nxt = 1'b0;
                    gate_nxt   = 1'b0;
                    state_nxt  = TX_LO;
                end else if (expired) begin
                    err_nxt    = 1'b1;
                    alu_en_nxt = 1'b0;
                    gate_nxt   = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            TX_RD: begin
                err_nxt = RX_D_VLD;
                if (!TX_FIFO_FULL) begin
                    tx_data_nxt = rd_q;
                    tx_vld_nxt  = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            TX_LO: begin
                err_nxt = RX_D_VLD;
                if (!TX_FIFO_FULL) begin
                    tx_data_nxt = res_q[DATA_WIDTH-1:0];
                    tx_vld_nxt  = 1'b1;
                    state_nxt   = TX_HI;
                end
            end
            TX_HI: begin
                err_nxt = RX_D_VLD;
                if (!TX_FIFO_FULL) begin
                    tx_data_nxt = res_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
                    tx_vld_nxt  = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sys_ctrl_cmd_decoder.sv
// tb/tb_sys_ctrl_cmd_decoder.sv - self-checking bench for sys_ctrl_cmd_decoder
module tb_sys_ctrl_cmd_decoder;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RF_RD_DATA = '0;
    logic        RF_RD_VLD = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        TX_FIFO_FULL = 1'b0;
    logic        RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_ERR;
    logic [3:0]  RF_ADDR, ALU_FUN;
    logic [7:0]  RF_WR_DATA, TX_P_DATA;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int err_cnt = 0;
    int gate_bad = 0;
    int rd_cyc = 0;
    int err_cyc = 0;
    bit rand_full = 1'b0;
    logic alu_en_d = 1'b0;
    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    logic [3:0]  fun_q[$];

    sys_ctrl_cmd_decoder dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD), .ALU_OUT(ALU_OUT),
        .ALU_OUT_VLD(ALU_OUT_VLD), .TX_FIFO_FULL(TX_FIFO_FULL),
        .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR),
        .RF_WR_DATA(RF_WR_DATA), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Transaction monitor: records every observable event with its cycle stamp
    always @(negedge CLK) begin
        if (RST) begin
            alu_en_d = 1'b0;
        end else begin
            if (RF_WR_EN) wr_q.push_back({RF_ADDR, RF_WR_DATA});
            if (RF_RD_EN) begin rd_q.push_back(RF_ADDR); rd_cyc = cyc; end
            if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
            if (CMD_ERR) begin err_cnt++; err_cyc = cyc; end
            if (ALU_EN && !alu_en_d) fun_q.push_back(ALU_FUN);
            if (CLK_GATE_EN !== ALU_EN) gate_bad++;
            alu_en_d = ALU_EN;
        end
    end

    task automatic clear_obs();
        wr_q.delete(); rd_q.delete(); tx_q.delete(); fun_q.delete();
        err_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b; RX_D_VLD = 1'b1;
        @(negedge CLK);
        RX_D_VLD = 1'b0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        RF_RD_DATA = d; RF_RD_VLD = 1'b1;
        @(negedge CLK);
        RF_RD_VLD = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] r);
        ALU_OUT = r; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
    endtask

    task automatic wait_tx(input int n, output bit ok);
        for (int k = 0; k < 600; k++) begin
            if (tx_q.size() >= n) break;
            @(negedge CLK);
            if (rand_full) TX_FIFO_FULL = ($urandom_range(0, 2) == 0);
        end
        TX_FIFO_FULL = 1'b0;
        repeat (2) @(negedge CLK);
        ok = (tx_q.size() >= n);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if ({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD, CMD_ERR} !== 32'h0) begin
            bad++; $display("FAIL reset_outputs: got nonzero outputs addr=%h wd=%h fun=%h tx=%h, need all 0",
                            RF_ADDR, RF_WR_DATA, ALU_FUN, TX_P_DATA);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_write_read();
        bit ok;
        clear_obs();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'hAB);
        repeat (2) @(negedge CLK);
        total++;
        if (wr_q.size() != 1 || wr_q[0] !== 12'h5AB) begin
            bad++; $display("FAIL wr_single: got %0d writes first=%h, need 1 write 5AB", wr_q.size(), wr_q[0]);
        end
        total++;
        if (RF_ADDR !== 4'h5 || RF_WR_DATA !== 8'hAB) begin
            bad++; $display("FAIL wr_hold: got addr=%h data=%h, need 5/ab", RF_ADDR, RF_WR_DATA);
        end
        send_byte(8'hBB); send_byte(8'h05);
        pulse_rd(8'hAB);
        wait_tx(1, ok);
        total++;
        if (!ok || rd_q.size() != 1 || rd_q[0] !== 4'h5) begin
            bad++; $display("FAIL rd_req: got ok=%0d reads=%0d addr=%h, need 1 read at 5", ok, rd_q.size(), rd_q[0]);
        end
        total++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'hAB) begin
            bad++; $display("FAIL rd_tx: got %0d bytes first=%h, need one byte ab", tx_q.size(), tx_q[0]);
        end
        total++;
        if (err_cnt != 0) begin bad++; $display("FAIL wr_rd_err: got %0d errors, need 0", err_cnt); end
    endtask

    task automatic test_alu_ops();
        bit ok;
        clear_obs();
        send_byte(8'hCC); send_byte(8'd200); send_byte(8'd200); send_byte(8'h02);
        total++;
        if (ALU_EN !== 1'b1 || CLK_GATE_EN !== 1'b1) begin
            bad++; $display("FAIL alu_en_on: got en=%b gate=%b, need 1/1", ALU_EN, CLK_GATE_EN);
        end
        pulse_alu(16'h9C40);
        wait_tx(2, ok);
        total++;
        if (wr_q.size() != 2 || wr_q[0] !== 12'h0C8 || wr_q[1] !== 12'h1C8) begin
            bad++; $display("FAIL alu_opwr: got %0d writes %h %h, need 0c8 1c8", wr_q.size(), wr_q[0], wr_q[1]);
        end
        total++;
        if (fun_q.size() != 1 || fun_q[0] !== 4'h2) begin
            bad++; $display("FAIL alu_fun: got %0d ops fun=%h, need one op fun 2", fun_q.size(), fun_q[0]);
        end
        total++;
        if (!ok || tx_q.size() != 2 || tx_q[0] !== 8'h40 || tx_q[1] !== 8'h9C) begin
            bad++; $display("FAIL alu_tx: got %0d bytes %h %h, need 40 9c", tx_q.size(), tx_q[0], tx_q[1]);
        end
        total++;
        if (ALU_EN !== 1'b0 || CLK_GATE_EN !== 1'b0) begin
            bad++; $display("FAIL alu_en_off: got en=%b gate=%b, need 0/0", ALU_EN, CLK_GATE_EN);
        end
    endtask

    task automatic test_alu_no_operands();
        bit ok;
        clear_obs();
        send_byte(8'hDD); send_byte(8'h08);
        pulse_alu(16'h0011);
        wait_tx(2, ok);
        total++;
        if (wr_q.size() != 0 || fun_q.size() != 1 || fun_q[0] !== 4'h8) begin
            bad++; $display("FAIL nop_fun: got writes=%0d ops=%0d fun=%h, need 0 writes fun 8",
                            wr_q.size(), fun_q.size(), fun_q[0]);
        end
        total++;
        if (!ok || tx_q.size() != 2 || tx_q[0] !== 8'h11 || tx_q[1] !== 8'h00) begin
            bad++; $display("FAIL nop_tx: got %0d bytes %h %h, need 11 00", tx_q.size(), tx_q[0], tx_q[1]);
        end
    endtask

    task automatic test_fifo_full();
        clear_obs();
        TX_FIFO_FULL = 1'b1;
        send_byte(8'hDD); send_byte(8'h02);
        pulse_alu(16'h9C40);
        repeat (20) @(negedge CLK);
        total++;
        if (tx_q.size() != 0) begin bad++; $display("FAIL full_hold: got %0d pushes while full, need 0", tx_q.size()); end
        TX_FIFO_FULL = 1'b0;
        @(negedge CLK);
        total++;
        if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h40) begin
            bad++; $display("FAIL full_release_lo: got vld=%b data=%h, need 1/40", TX_D_VLD, TX_P_DATA);
        end
        @(negedge CLK);
        total++;
        if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h9C) begin
            bad++; $display("FAIL full_release_hi: got vld=%b data=%h, need 1/9c", TX_D_VLD, TX_P_DATA);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_bad_cmd();
        clear_obs();
        send_byte(8'h55);
        repeat (2) @(negedge CLK);
        total++;
        if (err_cnt != 1 || wr_q.size() != 0 || rd_q.size() != 0 || fun_q.size() != 0 || ALU_EN !== 1'b0) begin
            bad++; $display("FAIL bad_cmd: got err=%0d wr=%0d rd=%0d ops=%0d, need 1/0/0/0",
                            err_cnt, wr_q.size(), rd_q.size(), fun_q.size());
        end
    endtask

    task automatic test_timeout();
        clear_obs();
        send_byte(8'hBB); send_byte(8'h03);
        for (int k = 0; k < 400 && err_cnt == 0; k++) @(negedge CLK);
        total++;
        if (err_cnt != 1 || (err_cyc - rd_cyc) != 255) begin
            bad++; $display("FAIL rd_timeout: got err=%0d after %0d cycles, need 1 after 255", err_cnt, err_cyc - rd_cyc);
        end
        clear_obs();
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h11);
        repeat (2) @(negedge CLK);
        total++;
        if (wr_q.size() != 1 || wr_q[0] !== 12'h711) begin
            bad++; $display("FAIL post_timeout_idle: got %0d writes first=%h, need 711", wr_q.size(), wr_q[0]);
        end
        clear_obs();
        send_byte(8'hDD); send_byte(8'h03);
        for (int k = 0; k < 400 && err_cnt == 0; k++) @(negedge CLK);
        @(negedge CLK);
        total++;
        if (err_cnt != 1 || ALU_EN !== 1'b0 || CLK_GATE_EN !== 1'b0) begin
            bad++; $display("FAIL alu_timeout: got err=%0d en=%b gate=%b, need 1/0/0", err_cnt, ALU_EN, CLK_GATE_EN);
        end
    endtask

    task automatic test_dropped_bytes();
        bit ok;
        clear_obs();
        send_byte(8'hBB); send_byte(8'h03); send_byte(8'h77);
        pulse_rd(8'h3C);
        // Lands on the cycle the read byte is pushed and the FSM returns to IDLE
        send_byte(8'hAA);
        send_byte(8'h05); send_byte(8'h06);
        wait_tx(1, ok);
        total++;
        if (err_cnt != 4 || wr_q.size() != 0) begin
            bad++; $display("FAIL drop_err: got err=%0d writes=%0d, need 4/0", err_cnt, wr_q.size());
        end
        total++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h3C || rd_q.size() != 1 || rd_q[0] !== 4'h3) begin
            bad++; $display("FAIL drop_tx: got %0d bytes first=%h reads=%0d, need 3c, 1 read", tx_q.size(), tx_q[0], rd_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
        send_byte(8'hAA); send_byte(8'h12); send_byte(8'h22);
        repeat (2) @(negedge CLK);
        total++;
        if (wr_q.size() != 2 || wr_q[0] !== 12'h111 || wr_q[1] !== 12'h222 || err_cnt != 0) begin
            bad++; $display("FAIL back_to_back: got %0d writes %h %h err=%0d, need 111 222 err 0",
                            wr_q.size(), wr_q[0], wr_q[1], err_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        send_byte(8'hCC); send_byte(8'h0A);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if ({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD, CMD_ERR} !== 32'h0) begin
            bad++; $display("FAIL midframe_reset: got addr=%h wd=%h fun=%h, need all outputs 0", RF_ADDR, RF_WR_DATA, ALU_FUN);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        send_byte(8'hAA); send_byte(8'h0F); send_byte(8'hA5);
        repeat (2) @(negedge CLK);
        total++;
        if (wr_q.size() != 2 || wr_q[0] !== 12'h00A || wr_q[1] !== 12'hFA5 || err_cnt != 0) begin
            bad++; $display("FAIL post_reset_write: got %0d writes %h %h err=%0d, need 00a fa5",
                            wr_q.size(), wr_q[0], wr_q[1], err_cnt);
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_wr[$];
        logic [3:0]  exp_rd[$];
        logic [7:0]  exp_tx[$];
        logic [3:0]  exp_fun[$];
        int exp_err = 0;
        bit ok, all_ok = 1'b1;
        logic [7:0] a, b, f;
        logic [15:0] r;
        clear_obs();
        rand_full = 1'b1;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom); b = 8'($urandom); f = 8'($urandom); r = 16'($urandom);
            case ($urandom_range(0, 4))
                0: begin
                    send_byte(8'hAA); send_byte(a); send_byte(b);
                    exp_wr.push_back({a[3:0], b});
                end
                1: begin
                    send_byte(8'hBB); send_byte(a);
                    repeat ($urandom_range(0, 6)) @(negedge CLK);
                    pulse_rd(b);
                    exp_rd.push_back(a[3:0]); exp_tx.push_back(b);
                    wait_tx(exp_tx.size(), ok); all_ok &= ok;
                end
                2: begin
                    send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
                    repeat ($urandom_range(0, 6)) @(negedge CLK);
                    pulse_alu(r);
                    exp_wr.push_back({4'h0, a}); exp_wr.push_back({4'h1, b});
                    exp_fun.push_back(f[3:0]);
                    exp_tx.push_back(r % 256); exp_tx.push_back(r / 256);
                    wait_tx(exp_tx.size(), ok); all_ok &= ok;
                end
                3: begin
                    send_byte(8'hDD); send_byte(f);
                    repeat ($urandom_range(0, 6)) @(negedge CLK);
                    pulse_alu(r);
                    exp_fun.push_back(f[3:0]);
                    exp_tx.push_back(r % 256); exp_tx.push_back(r / 256);
                    wait_tx(exp_tx.size(), ok); all_ok &= ok;
                end
                default: begin
                    while (a == 8'hAA || a == 8'hBB || a == 8'hCC || a == 8'hDD) a = 8'($urandom);
                    send_byte(a);
                    exp_err++;
                end
            endcase
        end
        rand_full = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (!all_ok) begin bad++; $display("FAIL rnd_tx_timeout: got missing pushes, need all frames answered"); end
        total++;
        if (err_cnt != exp_err) begin bad++; $display("FAIL rnd_err: got %0d, need %0d", err_cnt, exp_err); end
        total++;
        if (wr_q.size() != exp_wr.size() || rd_q.size() != exp_rd.size() ||
            tx_q.size() != exp_tx.size() || fun_q.size() != exp_fun.size()) begin
            bad++; $display("FAIL rnd_counts: got wr=%0d rd=%0d tx=%0d fun=%0d, need %0d %0d %0d %0d",
                            wr_q.size(), rd_q.size(), tx_q.size(), fun_q.size(),
                            exp_wr.size(), exp_rd.size(), exp_tx.size(), exp_fun.size());
        end else begin
            foreach (exp_wr[i]) begin
                total++;
                if (wr_q[i] !== exp_wr[i]) begin bad++; $display("FAIL rnd_wr[%0d]: got %h, need %h", i, wr_q[i], exp_wr[i]); end
            end
            foreach (exp_rd[i]) begin
                total++;
                if (rd_q[i] !== exp_rd[i]) begin bad++; $display("FAIL rnd_rd[%0d]: got %h, need %h", i, rd_q[i], exp_rd[i]); end
            end
            foreach (exp_tx[i]) begin
                total++;
                if (tx_q[i] !== exp_tx[i]) begin bad++; $display("FAIL rnd_tx[%0d]: got %h, need %h", i, tx_q[i], exp_tx[i]); end
            end
            foreach (exp_fun[i]) begin
                total++;
                if (fun_q[i] !== exp_fun[i]) begin bad++; $display("FAIL rnd_fun[%0d]: got %h, need %h", i, fun_q[i], exp_fun[i]); end
            end
        end
        total++;
        if (gate_bad != 0) begin bad++; $display("FAIL gate_tracks_en: got %0d differing cycles, need 0", gate_bad); end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_write_read();
        test_alu_ops();
        test_alu_no_operands();
        test_fifo_full();
        test_bad_cmd();
        test_timeout();
        test_dropped_bytes();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end
endmodule

// File: doc/sys_ctrl_cmd_decoder.md
# sys_ctrl_cmd_decoder

Command front-end of the system controller on the REF_CLK domain. It consumes the synchronised byte stream from the UART receiver and decodes the four frame types into register-file and ALU transactions. It then returns read data or ALU results as bytes toward the UART TX FIFO. It sits between the RX data synchroniser and the REG_FILE/ALU/TX FIFO.

## Interface
- DATA_WIDTH, 8, byte width of RX/TX/register data
- ADDR_WIDTH, 4, register-file address width; address bytes are truncated to the low ADDR_WIDTH bits
- FUN_WIDTH, 4, ALU function code width; FUN bytes are truncated
- ALU_OUT_WIDTH, 16, ALU result width; always 2×DATA_WIDTH
- TIMEOUT, 255, max cycles to wait for RF_RD_VLD / ALU_OUT_VLD

Ports:
- CLK  in  1  system (REF) clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- RF_RD_DATA  in  DATA_WIDTH  register-file read data
- RF_RD_VLD  in  1  read data valid strobe
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result
- ALU_OUT_VLD  in  1  ALU result valid strobe
- TX_FIFO_FULL  in  1  TX FIFO cannot accept a byte
- RF_WR_EN  out  1  register write strobe
- RF_RD_EN  out  1  register read strobe
- RF_ADDR  out  ADDR_WIDTH  register address
- RF_WR_DATA  out  DATA_WIDTH  register write data
- ALU_EN  out  1  ALU operation enable
- ALU_FUN  out  FUN_WIDTH  ALU function code
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
- TX_D_VLD  out  1  one-cycle push strobe
- CMD_ERR  out  1  one-cycle error strobe

## Operation
- Command bytes: 0xAA = RF write (addr, data); 0xBB = RF read (addr); 0xCC = ALU with operands (A, B, FUN); 0xDD = ALU without operands (FUN).
- Any other byte in IDLE: pulse CMD_ERR and stay in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_S, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- IDLE: 0xAA→WR_ADDR; 0xBB→RD_ADDR; 0xCC→OP_A; 0xDD→ALU_FUN_S.
- WR_ADDR: latch the address byte →WR_DATA. WR_DATA: on the byte, issue the RF write →IDLE.
- RD_ADDR: on the byte, issue RF_RD_EN →RD_WAIT. RD_WAIT: on RF_RD_VLD, capture the data →TX_RD.
- OP_A: write the byte to RF address 0 →OP_B. OP_B: write the byte to RF address 1 →ALU_FUN_S.
- ALU_FUN_S: on the byte, latch ALU_FUN, assert ALU_EN and CLK_GATE_EN →ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, capture the result, drop ALU_EN and CLK_GATE_EN →TX_LO.
- TX_RD / TX_LO / TX_HI: when !TX_FIFO_FULL, push the byte with TX_D_VLD. TX_RD→IDLE, TX_LO→TX_HI, TX_HI→IDLE. Low byte is sent first, then the high byte.
- While the FIFO is full, hold the state and byte; no TX_D_VLD is issued.
- RX_D_VLD in RD_WAIT, ALU_WAIT or any TX state: the byte is dropped and CMD_ERR pulses.
- Timeout: a cycle counter starts on entry to RD_WAIT or ALU_WAIT. After TIMEOUT cycles with no valid strobe: pulse CMD_ERR, clear ALU_EN and CLK_GATE_EN, go to IDLE.
- Reset mid-frame: the partial frame is discarded, the FSM returns to IDLE, and all outputs take their reset values.

## Timing
- All outputs are registered.
- Reset values: every strobe/enable is 0; RF_ADDR, RF_WR_DATA, ALU_FUN and TX_P_DATA are 0; state is IDLE.
- RF_WR_EN / RF_RD_EN: single-cycle pulse in the cycle after the triggering RX_D_VLD. RF_ADDR and RF_WR_DATA are valid in the same cycle and held until the next transaction.
- ALU_EN and CLK_GATE_EN: asserted from the cycle after the FUN byte through the cycle in which ALU_OUT_VLD is sampled.
- TX_D_VLD: at the earliest, one cycle after the capture of RF_RD_VLD or ALU_OUT_VLD. The low and high result bytes are pushed in consecutive cycles if the FIFO is not full.
- RX_D_VLD arriving in the same cycle as a return to IDLE is treated as a dropped byte (CMD_ERR).
- The counter is ⌈log2(TIMEOUT+1)⌉ bits and saturates; it does not wrap.

## Test plan
- 0xAA,0x05,0xAB → one RF_WR_EN, RF_ADDR=5, RF_WR_DATA=0xAB. Then 0xBB,0x05 with RF_RD_DATA=0xAB → RF_RD_EN, then TX_P_DATA=0xAB.
- 0xCC,200,200,0x02 with ALU_OUT=0x9C40 → RF writes 200@0 and 200@1, ALU_FUN=2, then TX bytes 0x40 then 0x9C.
- 0xDD,0x08 with ALU_OUT=0x0011 → no RF writes, ALU_FUN=8, TX bytes 0x11, 0x00.
- TX_FIFO_FULL held high for 20 cycles during TX_LO → no push while full; 0x40 is pushed the cycle after full drops.
- Byte 0x55 in IDLE → CMD_ERR pulse, no RF/ALU activity. 0xBB,0x03 with no RF_RD_VLD → CMD_ERR after 255 cycles, FSM back in IDLE.
- RST asserted after 0xCC,0x0A → outputs at reset values; then 0xAA,0x0F,0xA5 → RF write 0xA5@15.
